async_receiver: RTL and testbench
=================================

ASYNC_RECEIVER -- requirements
Module: async_receiver

Interface
REQ-001 Parameter B, default 4: bit width of the bundled-data bus.
REQ-002 Parameter CW, default 8: width of the received-word counter.
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 rst  input  1  reset; synchronous and active-low (asserted when rst=0, sampled on posedge clk only).
REQ-005 rqst  input  1  four-phase request from the remote sender; asynchronous to clk.
REQ-006 BusData  input  B  bundled data from the sender; stable while rqst=1.
REQ-007 ack  output  1  four-phase acknowledge to the sender.
REQ-008 dout  output  B  received word presented to the local consumer.
REQ-009 valid  output  1  dout holds an unconsumed word.
REQ-010 rd  input  1  consumer takes dout on a cycle where valid=1 and rd=1.
REQ-011 cnt  output  CW  number of words accepted since reset, modulo 2^CW.

Function
REQ-012 rqst SHALL pass through a two-flop synchronizer; only the second-stage output (rqst_s) SHALL drive control logic.
REQ-013 BusData SHALL NOT be synchronized; it SHALL be sampled only on the edge that moves IDLE->ACK.
REQ-014 FSM states SHALL be IDLE and ACK; ack SHALL equal 1 exactly when the state register is ACK.
REQ-015 IDLE->ACK SHALL occur on the edge where rqst_s=1 and (valid=0 or rd=1); that same edge loads dout<=BusData, sets valid=1 and increments cnt.
REQ-016 In IDLE with rqst_s=1, valid=1 and rd=0, the FSM SHALL remain in IDLE with ack=0, stalling the sender until the consumer reads.
REQ-017 ACK->IDLE SHALL occur on the edge where rqst_s=0; no data is captured on that edge.
REQ-018 In ACK, rqst_s=1 SHALL hold the FSM in ACK.
REQ-019 Latency: a rqst rise sampled by the first synchronizer stage at edge k SHALL give ack=1 and valid=1 after edge k+2, provided no stall.
REQ-020 A rd with valid=1 and no simultaneous capture SHALL clear valid on the next edge; a simultaneous rd and capture SHALL leave valid=1 with the new word.
REQ-021 rd while valid=0 SHALL have no effect.
REQ-022 cnt SHALL wrap from 2^CW-1 to 0 without any flag.
REQ-023 Exactly one word SHALL be captured per complete rqst high/low cycle.

Reset
REQ-024 With rst=0 at a posedge: state=IDLE, ack=0, valid=0, dout=0, cnt=0, both synchronizer flops=0.
REQ-025 Reset mid-transfer SHALL abandon the transfer; if rqst is still 1 after release, it SHALL be treated as a new request after the 2-cycle synchronizer delay.

Structure
REQ-026 A shared package async_hs_pkg SHALL hold the state encoding constants (IDLE=0, ACK=1) and the default bus width, shared with the sender.
REQ-027 The two-flop synchronizer SHALL be a separate sub-module async_sync2 (1-bit, clk, rst, d, q).
REQ-028 ack, valid, dout and cnt SHALL be driven directly from registers.

Verification
REQ-029 Single word: BusData=4'hA, rqst 0->1 at edge 0, rd=1 -> ack=1, valid=1, dout=4'hA, cnt=1 after edge 2; rqst->0 -> ack=0 two edges later.
REQ-030 Backpressure: first word 4'h3 captured, rd=0, second rqst with 4'h5 -> ack stays 0, dout stays 4'h3; rd=1 for one cycle -> 4'h5 captured on that edge, ack rises.
REQ-031 Back-to-back with sender model: 16 words 0..F with rd=1 -> all received in order, cnt=16, no duplicates.
REQ-032 Wrap: CW=2, five words -> cnt sequence 1,2,3,0,1.
REQ-033 Reset mid-transfer: rst=0 while in ACK with rqst=1 -> ack=0, valid=0, cnt=0 next edge; rst=1 with rqst still 1 -> ack=1 two edges after release.
REQ-034 Simultaneous rd and capture: valid=1 (dout=4'h1), rd=1 on capture edge of 4'h2 -> valid stays 1, dout=4'h2.

Source files
------------

// File: rtl/async_hs_pkg.sv
// Shared four-phase handshake definitions: FSM state encoding and default bus width,
// common to the sender and the receiver.
package async_hs_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } hs_state_t;

  localparam int unsigned HS_BUS_W = 4;

endpackage

// File: rtl/async_sync2.sv
// Two-flop synchronizer for a single asynchronous control bit.
module async_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

// File: rtl/async_receiver.sv
// Four-phase bundled-data receiver: synchronizes rqst, captures BusData into a
// one-word holding register and counts accepted words.
module async_receiver
  import async_hs_pkg::*;
#(
  parameter int unsigned B  = HS_BUS_W,
  parameter int unsigned CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rqst,
  input  logic [B-1:0]  BusData,
  output logic          ack,
  output logic [B-1:0]  dout,
  output logic          valid,
  input  logic          rd,
  output logic [CW-1:0] cnt
);

  hs_state_t     r_state;
  hs_state_t     w_state_nxt;
  logic          w_rqst_s;
  logic          w_capture;
  logic [B-1:0]  r_dout;
  logic          r_valid;
  logic [CW-1:0] r_cnt;

  async_sync2 u_sync_rqst (
    .clk (clk),
    .rst (rst),
    .d   (rqst),
    .q   (w_rqst_s)
  );

  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  // Accept a new word only when the holding register is free or being read this cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_rqst_s && (!r_valid || rd)) begin
          w_state_nxt = ACK;
          w_capture   = 1'b1;
        end
      end
      ACK: begin
        if (!w_rqst_s) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_dout  <= '0;
      r_valid <= 1'b0;
      r_cnt   <= '0;
    end else if (w_capture) begin
      r_dout  <= BusData;
      r_valid <= 1'b1;
      r_cnt   <= r_cnt + CW'(1);
    end else if (rd && r_valid) begin
      r_valid <= 1'b0;
    end
  end

  assign ack   = 1'(r_state);
  assign dout  = r_dout;
  assign valid = r_valid;
  assign cnt   = r_cnt;

endmodule

// File: tb/tb_async_receiver.sv
// Directed bench for async_receiver: vector table for single word, backpressure and
// simultaneous read/capture, then hand sequences for mid-transfer reset, streaming and wrap.
module tb_async_receiver;

  logic       clk;
  logic       rst;
  logic       rqst;
  logic [3:0] BusData;
  logic       rd;
  logic       ack;
  logic [3:0] dout;
  logic       valid;
  logic [7:0] cnt;
  logic       ack2;
  logic [3:0] dout2;
  logic       valid2;
  logic [1:0] cnt2;

  int n_vec;
  int n_err;
  int n_taken;
  bit mon_en;
  bit ok;

  typedef struct {
    logic       rst;
    logic       rqst;
    logic [3:0] data;
    logic       rd;
    logic       ack;
    logic       valid;
    logic [3:0] dout;
    logic [7:0] cnt;
  } vec_t;

  vec_t vt[35];
  int   wrap_exp[5];

  async_receiver #(.B(4), .CW(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .rqst    (rqst),
    .BusData (BusData),
    .ack     (ack),
    .dout    (dout),
    .valid   (valid),
    .rd      (rd),
    .cnt     (cnt)
  );

  async_receiver #(.B(4), .CW(2)) dut2 (
    .clk     (clk),
    .rst     (rst),
    .rqst    (rqst),
    .BusData (BusData),
    .ack     (ack2),
    .dout    (dout2),
    .valid   (valid2),
    .rd      (rd),
    .cnt     (cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts words handed to the consumer while streaming.
  always @(posedge clk) begin
    if (mon_en && valid && rd) n_taken++;
  end

  function automatic vec_t mk(bit r, bit q, int d, bit rdi, bit a, bit v, int o, int c);
    vec_t x;
    x.rst   = r;
    x.rqst  = q;
    x.data  = 4'(d);
    x.rd    = rdi;
    x.ack   = a;
    x.valid = v;
    x.dout  = 4'(o);
    x.cnt   = 8'(c);
    return x;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_ack(input logic lvl, input string nm, output bit got);
    int k;
    k = 0;
    while (ack !== lvl && k < 20) begin
      tick();
      k++;
    end
    got = (ack === lvl);
    n_vec++;
    if (!got) begin
      n_err++;
      $display("FAIL %s: ack=%b expected %b within 20 cycles", nm, ack, lvl);
    end
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    n_taken = 0;
    mon_en  = 1'b0;
    rst     = 1'b0;
    rqst    = 1'b0;
    BusData = 4'h0;
    rd      = 1'b0;

    //          rst rq  d  rd | ack val dout cnt
    vt[ 0] = mk(0, 0, 4'h0, 0,  0, 0, 4'h0, 0);
    vt[ 1] = mk(0, 0, 4'h0, 0,  0, 0, 4'h0, 0);
    vt[ 2] = mk(1, 1, 4'hA, 1,  0, 0, 4'h0, 0);
    vt[ 3] = mk(1, 1, 4'hA, 1,  0, 0, 4'h0, 0);
    vt[ 4] = mk(1, 1, 4'hA, 1,  1, 1, 4'hA, 1);
    vt[ 5] = mk(1, 0, 4'hA, 1,  1, 0, 4'hA, 1);
    vt[ 6] = mk(1, 0, 4'hA, 0,  1, 0, 4'hA, 1);
    vt[ 7] = mk(1, 0, 4'hA, 0,  0, 0, 4'hA, 1);
    vt[ 8] = mk(1, 1, 4'h3, 1,  0, 0, 4'hA, 1);
    vt[ 9] = mk(1, 1, 4'h3, 1,  0, 0, 4'hA, 1);
    vt[10] = mk(1, 1, 4'h3, 0,  1, 1, 4'h3, 2);
    vt[11] = mk(1, 0, 4'h3, 0,  1, 1, 4'h3, 2);
    vt[12] = mk(1, 0, 4'h3, 0,  1, 1, 4'h3, 2);
    vt[13] = mk(1, 0, 4'h3, 0,  0, 1, 4'h3, 2);
    vt[14] = mk(1, 1, 4'h5, 0,  0, 1, 4'h3, 2);
    vt[15] = mk(1, 1, 4'h5, 0,  0, 1, 4'h3, 2);
    vt[16] = mk(1, 1, 4'h5, 0,  0, 1, 4'h3, 2);
    vt[17] = mk(1, 1, 4'h5, 0,  0, 1, 4'h3, 2);
    vt[18] = mk(1, 1, 4'h5, 1,  1, 1, 4'h5, 3);
    vt[19] = mk(1, 0, 4'h5, 0,  1, 1, 4'h5, 3);
    vt[20] = mk(1, 0, 4'h5, 0,  1, 1, 4'h5, 3);
    vt[21] = mk(1, 0, 4'h5, 0,  0, 1, 4'h5, 3);
    vt[22] = mk(1, 0, 4'h5, 1,  0, 0, 4'h5, 3);
    vt[23] = mk(1, 1, 4'h1, 0,  0, 0, 4'h5, 3);
    vt[24] = mk(1, 1, 4'h1, 0,  0, 0, 4'h5, 3);
    vt[25] = mk(1, 1, 4'h1, 0,  1, 1, 4'h1, 4);
    vt[26] = mk(1, 0, 4'h1, 0,  1, 1, 4'h1, 4);
    vt[27] = mk(1, 0, 4'h1, 0,  1, 1, 4'h1, 4);
    vt[28] = mk(1, 0, 4'h1, 0,  0, 1, 4'h1, 4);
    vt[29] = mk(1, 1, 4'h2, 0,  0, 1, 4'h1, 4);
    vt[30] = mk(1, 1, 4'h2, 0,  0, 1, 4'h1, 4);
    vt[31] = mk(1, 1, 4'h2, 1,  1, 1, 4'h2, 5);
    vt[32] = mk(1, 0, 4'h2, 0,  1, 1, 4'h2, 5);
    vt[33] = mk(1, 0, 4'h2, 0,  1, 1, 4'h2, 5);
    vt[34] = mk(1, 0, 4'h2, 0,  0, 1, 4'h2, 5);

    wrap_exp[0] = 1;
    wrap_exp[1] = 2;
    wrap_exp[2] = 3;
    wrap_exp[3] = 0;
    wrap_exp[4] = 1;

    #2;
    for (int i = 0; i < 35; i++) begin
      rst     = vt[i].rst;
      rqst    = vt[i].rqst;
      BusData = vt[i].data;
      rd      = vt[i].rd;
      tick();
      chk($sformatf("vec%0d.ack", i),   32'(ack),   32'(vt[i].ack));
      chk($sformatf("vec%0d.valid", i), 32'(valid), 32'(vt[i].valid));
      chk($sformatf("vec%0d.dout", i),  32'(dout),  32'(vt[i].dout));
      chk($sformatf("vec%0d.cnt", i),   32'(cnt),   32'(vt[i].cnt));
    end

    // Reset in the middle of a transfer with rqst held high throughout.
    rqst    = 1'b1;
    BusData = 4'h7;
    rd      = 1'b1;
    wait_ack(1'b1, "midrst.enter_ack", ok);
    rst = 1'b0;
    tick();
    chk("midrst.ack",   32'(ack),   32'd0);
    chk("midrst.valid", 32'(valid), 32'd0);
    chk("midrst.cnt",   32'(cnt),   32'd0);
    chk("midrst.dout",  32'(dout),  32'd0);
    rst = 1'b1;
    tick();
    chk("midrst.rel1.ack", 32'(ack), 32'd0);
    tick();
    chk("midrst.rel2.ack", 32'(ack), 32'd0);
    tick();
    chk("midrst.rel3.ack",  32'(ack),  32'd1);
    chk("midrst.rel3.dout", 32'(dout), 32'h7);
    chk("midrst.rel3.cnt",  32'(cnt),  32'd1);

    // Streaming with a four-phase sender model; the CW=2 instance checks wrap.
    rqst = 1'b0;
    rd   = 1'b1;
    rst  = 1'b0;
    tick();
    tick();
    rst    = 1'b1;
    mon_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      BusData = 4'(i);
      rqst    = 1'b1;
      wait_ack(1'b1, $sformatf("b2b%0d.ack_hi", i), ok);
      if (ok) begin
        chk($sformatf("b2b%0d.dout", i), 32'(dout), 32'(i));
        chk($sformatf("b2b%0d.cnt", i),  32'(cnt),  32'(i + 1));
        if (i < 5) chk($sformatf("wrap%0d.cnt", i), 32'(cnt2), 32'(wrap_exp[i]));
      end
      rqst = 1'b0;
      wait_ack(1'b0, $sformatf("b2b%0d.ack_lo", i), ok);
    end
    tick();
    tick();
    mon_en = 1'b0;
    chk("b2b.final_cnt", 32'(cnt),     32'd16);
    chk("b2b.taken",     32'(n_taken), 32'd16);
    chk("wrap.final",    32'(cnt2),    32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
